coco_mem_access_unit: RTL and testbench

//  MEM-stage load/store sequencer for the Mips-C core; sits directly upstream of the load data-extension stage.

---
 rtl/coco_mem_pkg.sv | 36 +++
 rtl/coco_mem_access_unit_if.sv | 34 +++
 rtl/coco_store_lane_align.sv | 25 ++
 rtl/coco_mem_access_unit.sv | 141 ++++++++++++++
 tb/tb_coco_mem_access_unit.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coco_mem_pkg.sv
// Shared constants, state encoding and alignment helpers for the MEM-stage
// load/store sequencer.
package coco_mem_pkg;

    localparam logic [2:0] LS_WORD = 3'b000;
    localparam logic [2:0] LS_BU   = 3'b001;
    localparam logic [2:0] LS_HU   = 3'b010;
    localparam logic [2:0] LS_BS   = 3'b011;
    localparam logic [2:0] LS_HS   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mau_state_e;

    function automatic logic is_byte(input logic [2:0] funct);
        return (funct == LS_BU) || (funct == LS_BS);
    endfunction

    function automatic logic is_half(input logic [2:0] funct);
        return (funct == LS_HU) || (funct == LS_HS);
    endfunction

    // Unlisted codes fall through to word size.
    function automatic logic misaligned(input logic [2:0] funct, input logic [1:0] a1a0);
        if (is_byte(funct)) begin
            return 1'b0;
        end
        if (is_half(funct)) begin
            return a1a0[0];
        end
        return a1a0 != 2'b00;
    endfunction

endpackage

// File: rtl/coco_mem_access_unit_if.sv
// Data-bus interface between the MEM-stage sequencer (master) and memory (slave).
// Handshake: master raises bus_req with bus_we/addr/be/wdata stable and holds them
// until the slave returns a single-cycle bus_ack; bus_rdata is valid only with bus_ack.
interface coco_mem_access_unit_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );

endinterface

// File: rtl/coco_store_lane_align.sv
// Store lane steering: replicates right-justified store data across the lanes
// and derives byte enables from the access size and address low bits.
module coco_store_lane_align
    import coco_mem_pkg::*;
(
    input  logic [2:0]  ls_funct_i,
    input  logic [1:0]  a1a0_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        if (is_byte(ls_funct_i)) begin
            be_o    = 4'b0001 << a1a0_i;
            wdata_o = {4{wdata_i[7:0]}};
        end else if (is_half(ls_funct_i)) begin
            be_o    = a1a0_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
        end
    end

endmodule

// File: rtl/coco_mem_access_unit.sv
// MEM-stage load/store sequencer: runs one req/ack data-bus transaction per
// pipeline slot, stalls upstream meanwhile, and hands loaded words to extension.
module coco_mem_access_unit
    import coco_mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mem_rd_i,
    input  logic                          mem_wr_i,
    input  logic [2:0]                    ls_funct_i,
    input  logic [31:0]                   addr_i,
    input  logic [31:0]                   wdata_i,
    output logic                          stall_o,
    output logic                          addr_err_o,
    output logic                          bus_timeout_o,
    coco_mem_access_unit_if.master        bus,
    output logic [31:0]                   ext_din_o,
    output logic [2:0]                    ext_funct_o,
    output logic [1:0]                    ext_a1a0_o,
    output logic                          ld_valid_o,
    output mau_state_e                    state_o
);

    mau_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [31:0]       bus_addr_q;
    logic [3:0]        bus_be_q;
    logic [31:0]       bus_wdata_q;
    logic              addr_err_q;
    logic              timeout_q;
    logic              ld_valid_q;
    logic [31:0]       ext_din_q;
    logic [2:0]        ext_funct_q;
    logic [1:0]        ext_a1a0_q;

    logic        req;
    logic        is_store;
    logic        bad_align;
    logic        accept;
    logic        timeout_hit;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;

    coco_store_lane_align u_lane (
        .ls_funct_i (ls_funct_i),
        .a1a0_i     (addr_i[1:0]),
        .wdata_i    (wdata_i),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata)
    );

    // A simultaneous read and write request is handled as a store.
    assign req         = mem_rd_i | mem_wr_i;
    assign is_store    = mem_wr_i;
    assign bad_align   = misaligned(ls_funct_i, addr_i[1:0]);
    assign accept      = (state_q == ST_IDLE) && req && !bad_align;
    assign timeout_hit = cnt_q == CNT_W'(TIMEOUT_CYC - 1);

    // Stall must rise in the accepting cycle so the slot is held before WAIT.
    assign stall_o = (state_q == ST_WAIT) || accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            addr_err_q  <= 1'b0;
            timeout_q   <= 1'b0;
            ld_valid_q  <= 1'b0;
            ext_din_q   <= '0;
            ext_funct_q <= '0;
            ext_a1a0_q  <= '0;
        end else begin
            addr_err_q <= 1'b0;
            timeout_q  <= 1'b0;
            ld_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req && bad_align) begin
                        addr_err_q <= 1'b1;
                    end else if (accept) begin
                        state_q     <= ST_WAIT;
                        cnt_q       <= '0;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= is_store;
                        bus_addr_q  <= {addr_i[31:2], 2'b00};
                        bus_be_q    <= is_store ? lane_be : 4'b1111;
                        bus_wdata_q <= is_store ? lane_wdata : 32'd0;
                        if (!is_store) begin
                            ext_funct_q <= ls_funct_i;
                            ext_a1a0_q  <= addr_i[1:0];
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus.bus_ack) begin
                        bus_req_q <= 1'b0;
                        state_q   <= ST_DONE;
                        if (!bus_we_q) begin
                            ext_din_q  <= bus.bus_rdata;
                            ld_valid_q <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        bus_req_q <= 1'b0;
                        timeout_q <= 1'b1;
                        ext_din_q <= '0;
                        state_q   <= ST_DONE;
                    end
                end
                // One unstalled cycle lets the pipeline advance; the old request is not replayed.
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;

    assign addr_err_o    = addr_err_q;
    assign bus_timeout_o = timeout_q;
    assign ld_valid_o    = ld_valid_q;
    assign ext_din_o     = ext_din_q;
    assign ext_funct_o   = ext_funct_q;
    assign ext_a1a0_o    = ext_a1a0_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_coco_mem_access_unit.sv
// Bench for the MEM-stage sequencer: directed cases plus randomized accesses,
// with expected bus/load/error events queued by the driver and popped by a monitor.
module tb_coco_mem_access_unit;
    import coco_mem_pkg::*;

    localparam int TMO = 64;

    localparam logic [2:0] K_REQ = 3'd1;
    localparam logic [2:0] K_LD  = 3'd2;
    localparam logic [2:0] K_ERR = 3'd3;
    localparam logic [2:0] K_TO  = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [2:0]  f;
        logic [1:0]  a1a0;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic        clk;
    logic        reset;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [2:0]  ls_funct_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        addr_err_o;
    logic        bus_timeout_o;
    logic [31:0] ext_din_o;
    logic [2:0]  ext_funct_o;
    logic [1:0]  ext_a1a0_o;
    logic        ld_valid_o;
    mau_state_e  state_o;
    logic        prev_req;

    coco_mem_access_unit_if bus ();

    coco_mem_access_unit #(.TIMEOUT_CYC(TMO), .CNT_W(7)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_rd_i      (mem_rd_i),
        .mem_wr_i      (mem_wr_i),
        .ls_funct_i    (ls_funct_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .addr_err_o    (addr_err_o),
        .bus_timeout_o (bus_timeout_o),
        .bus           (bus.master),
        .ext_din_o     (ext_din_o),
        .ext_funct_o   (ext_funct_o),
        .ext_a1a0_o    (ext_a1a0_o),
        .ld_valid_o    (ld_valid_o),
        .state_o       (state_o)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: sizes and lane placement from plain arithmetic
    function automatic int size_of(input logic [2:0] f);
        case (f)
            3'd1, 3'd3: return 1;
            3'd2, 3'd4: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input int sz, input int off);
        if (sz == 4) return 4'hF;
        return 4'((sz == 1 ? 1 : 3) << off);
    endfunction

    function automatic logic [31:0] model_wd(input int sz, input logic [31:0] wd);
        if (sz == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    // Driver: call just after a rising edge; returns just after a rising edge in IDLE.
    // dly = number of WAIT cycles before ack; dly < 0 withholds the ack.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int dly, input logic [31:0] rword);
        int   sz;
        int   off;
        int   stall_cnt;
        int   exp_stall;
        bit   done;
        exp_t e;
        sz  = size_of(f);
        off = int'(a[1:0]);
        mem_rd_i = rd; mem_wr_i = wr; ls_funct_i = f; addr_i = a; wdata_i = wd;
        if ((off % sz) != 0) begin
            e = '0; e.kind = K_ERR;
            exp_q.push_back(e);
            @(negedge clk);
            chk("stall_misaligned", {31'd0, stall_o}, 32'd0);
            @(posedge clk); #1;
            mem_rd_i = 1'b0; mem_wr_i = 1'b0;
            return;
        end
        e = '0; e.kind = K_REQ; e.we = wr; e.a = {a[31:2], 2'b00};
        e.be = wr ? model_be(sz, off) : 4'hF;
        e.d  = wr ? model_wd(sz, wd) : 32'd0;
        exp_q.push_back(e);
        if (dly < 0) begin
            e = '0; e.kind = K_TO;
            exp_q.push_back(e);
        end else if (!wr) begin
            e = '0; e.kind = K_LD; e.d = rword; e.f = f; e.a1a0 = a[1:0];
            exp_q.push_back(e);
        end
        exp_stall = (dly < 0) ? 1 + TMO : dly + 2;
        stall_cnt = 0;
        done = 0;
        @(negedge clk);
        if (stall_o) stall_cnt++;
        for (int c = 0; c < TMO + 20 && !done; c++) begin
            @(posedge clk); #1;
            bus.bus_ack   = (c == dly);
            bus.bus_rdata = (c == dly) ? rword : $urandom;
            @(negedge clk);
            if (stall_o) stall_cnt++;
            else done = 1;
        end
        chk("pipeline_released", {31'd0, done}, 32'd1);
        chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        chk("req_low_in_done", {31'd0, bus.bus_req}, 32'd0);
        // Request stays on the inputs through DONE; it must not start a new bus cycle.
        @(posedge clk); #1;
        bus.bus_ack = 1'b0;
        mem_rd_i = 1'b0; mem_wr_i = 1'b0;
    endtask

    task automatic mon_take(input logic [2:0] kind, output exp_t e, output bit ok);
        ok = 0;
        e  = '0;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_event: got kind %0d want none", kind);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", {29'd0, kind}, {29'd0, e.kind});
        ok = (kind == e.kind);
    endtask

    // Monitor: every DUT output event must match the head of the expected queue
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (addr_err_o) begin
            mon_take(K_ERR, e, ok);
            if (ok) chk("err_no_bus", {31'd0, bus.bus_req}, 32'd0);
        end
        if (ld_valid_o) begin
            mon_take(K_LD, e, ok);
            if (ok) begin
                chk("ext_din", ext_din_o, e.d);
                chk("ext_funct", {29'd0, ext_funct_o}, {29'd0, e.f});
                chk("ext_a1a0", {30'd0, ext_a1a0_o}, {30'd0, e.a1a0});
            end
        end
        if (bus_timeout_o) begin
            mon_take(K_TO, e, ok);
            if (ok) chk("timeout_ext_din", ext_din_o, 32'd0);
        end
        if (bus.bus_req && !prev_req) begin
            mon_take(K_REQ, e, ok);
            if (ok) begin
                chk("bus_addr", bus.bus_addr, e.a);
                chk("bus_we", {31'd0, bus.bus_we}, {31'd0, e.we});
                chk("bus_be", {28'd0, bus.bus_be}, {28'd0, e.be});
                chk("bus_wdata", bus.bus_wdata, e.d);
            end
        end
        prev_req <= bus.bus_req;
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        int          rw;
        int          dly;
        prev_req = 1'b0;
        reset = 1'b1;
        mem_rd_i = 1'b0; mem_wr_i = 1'b0; ls_funct_i = '0; addr_i = '0; wdata_i = '0;
        bus.bus_ack = 1'b0; bus.bus_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err_o}, 32'd0);
        chk("rst_timeout", {31'd0, bus_timeout_o}, 32'd0);
        chk("rst_req", {31'd0, bus.bus_req}, 32'd0);
        chk("rst_we", {31'd0, bus.bus_we}, 32'd0);
        chk("rst_ld_valid", {31'd0, ld_valid_o}, 32'd0);
        chk("rst_bus_addr", bus.bus_addr, 32'd0);
        chk("rst_bus_be", {28'd0, bus.bus_be}, 32'd0);
        chk("rst_bus_wdata", bus.bus_wdata, 32'd0);
        chk("rst_ext_din", ext_din_o, 32'd0);
        chk("rst_ext_funct", {29'd0, ext_funct_o}, 32'd0);
        chk("rst_ext_a1a0", {30'd0, ext_a1a0_o}, 32'd0);
        chk("rst_state", 32'(state_o), 32'(ST_IDLE));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        access(1'b1, 1'b0, LS_BS, 32'h0000_1003, 32'd0, 2, 32'h80FF_1234);
        access(1'b0, 1'b1, LS_HU, 32'h0000_2002, 32'h0000_BEEF, 1, 32'd0);
        access(1'b1, 1'b0, LS_WORD, 32'h0000_3001, 32'd0, 0, 32'd0);
        access(1'b1, 1'b0, LS_WORD, 32'h0000_6000, 32'd0, -1, 32'd0);
        access(1'b0, 1'b1, LS_BU, 32'h0000_4001, 32'h0000_0044, 0, 32'd0);
        access(1'b1, 1'b0, LS_HU, 32'h0000_4000, 32'd0, 0, 32'hCAFE_F00D);
        access(1'b1, 1'b1, LS_HS, 32'h0000_7006, 32'h1234_5678, 3, 32'd0);

        // Reset during WAIT followed by a late ack
        mem_rd_i = 1'b1; ls_funct_i = LS_WORD; addr_i = 32'h0000_5000;
        begin
            exp_t e;
            e = '0; e.kind = K_REQ; e.a = 32'h0000_5000; e.be = 4'hF;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; mem_rd_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("reset_req_low", {31'd0, bus.bus_req}, 32'd0);
        chk("reset_state_idle", 32'(state_o), 32'(ST_IDLE));
        @(posedge clk); #1;
        bus.bus_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_ignored_state", 32'(state_o), 32'(ST_IDLE));
        chk("late_ack_no_load", {31'd0, ld_valid_o}, 32'd0);
        @(posedge clk); #1;

        // Randomized accesses
        for (int i = 0; i < 60; i++) begin
            f  = 3'($urandom_range(0, 4));
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = (size_of(f) == 1) ? a[1:0] : (size_of(f) == 2 ? {a[1], 1'b0} : 2'b00);
            rw  = $urandom_range(0, 2);
            dly = ($urandom_range(0, 15) == 0) ? -1 : $urandom_range(0, 5);
            access(rw != 1, rw != 0, f, a, $urandom, dly, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
